// File: rtl/dmem_wbuf_if.sv
// Memory-stage bus between the pipeline (master) and the data-memory responder (slave).
interface dmem_wbuf_if;
  logic        wmem;
  logic        rmem;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        rvalid;
  logic        stall;
  logic        wb_empty;

  modport master (
    output wmem, rmem, addr, datain,
    input  dataout, rvalid, stall, wb_empty
  );

  modport slave (
    input  wmem, rmem, addr, datain,
    output dataout, rvalid, stall, wb_empty
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Data memory with a posted-write FIFO drained at one commit per DRAIN_CYCLES cycles;
// loads have one-cycle latency and forward from the youngest matching buffered store.
module dmem_wbuf #(
  parameter int unsigned AW           = 8,
  parameter int unsigned WB_DEPTH     = 4,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic        clk,
  input logic        clrn,
  dmem_wbuf_if.slave bus
);
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] CntReload = DW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] CountFull = CW'(WB_DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q;
  logic [DW-1:0] cnt_q;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wb_idx_q  [WB_DEPTH];
  logic [31:0]   wb_data_q [WB_DEPTH];
  logic [31:0]   mem_q     [2**AW];
  logic [31:0]   dataout_q;
  logic          rvalid_q;

  logic [AW-1:0] widx;
  logic          commit_now, push, ld;
  logic          fwd_hit;
  logic [31:0]   fwd_data, load_data;
  logic [PW-1:0] pos;
  logic          unused_addr;

  assign widx        = bus.addr[AW+1:2];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  assign commit_now   = (state_q == StBusy) && (cnt_q == '0);
  assign bus.stall    = bus.wmem && (count_q == CountFull) && !commit_now;
  assign push         = bus.wmem && !bus.stall;
  assign ld           = bus.rmem && !bus.wmem;
  assign bus.wb_empty = (count_q == '0) && (state_q == StIdle);
  assign bus.dataout  = dataout_q;
  assign bus.rvalid   = rvalid_q;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pos      = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      pos = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wb_idx_q[pos] == widx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[pos];
      end
    end
    load_data = fwd_hit ? fwd_data : mem_q[widx];
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      dataout_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      if (push)       tail_q <= tail_q + PW'(1);
      if (commit_now) head_q <= head_q + PW'(1);
      count_q  <= count_q + CW'(push) - CW'(commit_now);
      rvalid_q <= ld;
      if (ld) dataout_q <= load_data;

      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q <= StBusy;
            cnt_q   <= CntReload;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DW'(1);
          end else if (count_q > CW'(1)) begin
            cnt_q <= CntReload;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage arrays carry no reset; the array is never written on a reset edge.
  always_ff @(posedge clk) begin
    if (clrn && commit_now) mem_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
    if (clrn && push) begin
      wb_idx_q[tail_q]  <= widx;
      wb_data_q[tail_q] <= bus.datain;
    end
  end
endmodule

// File: tb/tb_dmem_wbuf.sv
// Bench for dmem_wbuf: commit-schedule model checked every cycle plus directed literal checks.
module tb_dmem_wbuf;
  localparam int D     = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  dmem_wbuf_if bus();

  dmem_wbuf #(.AW(8), .WB_DEPTH(DEPTH), .DRAIN_CYCLES(D)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: each accepted store gets a commit edge = max(accept+1+D, previous commit+D).
  typedef struct {
    int          idx;
    logic [31:0] data;
    int          ce;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mm[int];
  int          t = 0;
  int          last_ce = 0;
  bit          started = 0;
  logic        exp_rv;
  logic [31:0] exp_do;
  bit          do_known;
  bit          m_cnow, m_stall, m_found;
  int          m_widx, m_ce;
  ent_t        m_e;

  always @(negedge clk) begin
    m_cnow  = (q.size() > 0) && (q[0].ce == t);
    m_stall = bus.wmem && (q.size() == DEPTH) && !m_cnow;
    if (started) begin
      chk("m_rvalid", bus.rvalid, exp_rv);
      if (do_known) chk("m_dataout", bus.dataout, exp_do);
      chk("m_wb_empty", bus.wb_empty, q.size() == 0);
      chk("m_stall", bus.stall, m_stall);
    end
    m_widx = int'((bus.addr >> 2) & 32'hFF);
    if (!clrn) begin
      q.delete();
      last_ce  = 0;
      exp_rv   = 1'b0;
      exp_do   = '0;
      do_known = 1'b1;
      started  = 1'b1;
    end else begin
      if (bus.rmem && !bus.wmem) begin
        exp_rv  = 1'b1;
        m_found = 1'b0;
        foreach (q[i]) begin
          if (q[i].idx == m_widx) begin
            exp_do  = q[i].data;
            m_found = 1'b1;
          end
        end
        if (m_found) do_known = 1'b1;
        else if (mm.exists(m_widx)) begin
          exp_do   = mm[m_widx];
          do_known = 1'b1;
        end else do_known = 1'b0;
      end else begin
        exp_rv = 1'b0;
      end
      if (m_cnow) begin
        mm[q[0].idx] = q[0].data;
        void'(q.pop_front());
      end
      if (bus.wmem && !m_stall) begin
        m_ce      = (t + 1 + D > last_ce + D) ? t + 1 + D : last_ce + D;
        m_e.idx   = m_widx;
        m_e.data  = bus.datain;
        m_e.ce    = m_ce;
        q.push_back(m_e);
        last_ce   = m_ce;
      end
    end
    t++;
  end

  // Stimulus: inputs change 1 time unit after each rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       output bit first_stall, output int waits);
    bus.wmem   = 1'b1;
    bus.rmem   = 1'b0;
    bus.addr   = a;
    bus.datain = d;
    waits      = 0;
    #2;
    first_stall = bus.stall;
    while (bus.stall && waits < 50) begin
      @(posedge clk);
      #3;
      waits++;
    end
    chk("store_accept", bus.stall, 1'b0);
    @(posedge clk);
    #1;
    bus.wmem = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic rv, output logic [31:0] dout);
    bus.wmem = 1'b0;
    bus.rmem = 1'b1;
    bus.addr = a;
    @(posedge clk);
    #1;
    rv       = bus.rvalid;
    dout     = bus.dataout;
    bus.rmem = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.wmem = 1'b0;
    bus.rmem = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    bus.wmem = 1'b0;
    bus.rmem = 1'b0;
    while (!bus.wb_empty && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_empty", bus.wb_empty, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish within time limit");
    $fatal(1);
  end

  initial begin
    bit          s0 [8];
    int          w  [8];
    bit          fs;
    int          wt;
    logic        rv;
    logic [31:0] dout;

    clrn       = 1'b0;
    bus.wmem   = 1'b0;
    bus.rmem   = 1'b0;
    bus.addr   = '0;
    bus.datain = '0;
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b1;
    chk("rst_wb_empty", bus.wb_empty, 1'b1);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_dataout", bus.dataout, 32'h0);

    load(32'h14, rv, dout);
    chk("ld5_rvalid", rv, 1'b1);

    // Forwarding, then the same value from the array.
    store(32'h14, 32'hDEADBEEF, fs, wt);
    load(32'h14, rv, dout);
    chk("fwd_deadbeef", dout, 32'hDEADBEEF);
    wait_empty();
    load(32'h14, rv, dout);
    chk("arr_deadbeef", dout, 32'hDEADBEEF);

    // Youngest match wins.
    store(32'h20, 32'h1, fs, wt);
    store(32'h20, 32'h2, fs, wt);
    store(32'h20, 32'h3, fs, wt);
    load(32'h20, rv, dout);
    chk("youngest_fwd", dout, 32'h3);
    wait_empty();
    load(32'h20, rv, dout);
    chk("youngest_arr", dout, 32'h3);

    // Fill past capacity with wmem held through stalls.
    wait_empty();
    for (int k = 0; k < 8; k++) store(32'h100 + 32'(4 * k), 32'hC000_0000 + 32'(k), s0[k], w[k]);
    for (int k = 0; k < 6; k++) chk($sformatf("st%0d_stall", k + 1), s0[k], 1'b0);
    chk("st7_stall", s0[6], 1'b1);
    chk("st7_waits", w[6], 1);
    for (int k = 0; k < 8; k++) begin
      load(32'h100 + 32'(4 * k), rv, dout);
      chk($sformatf("rb%0d", k + 1), dout, 32'hC000_0000 + 32'(k));
    end
    wait_empty();

    // Simultaneous store and load: store only.
    bus.wmem   = 1'b1;
    bus.rmem   = 1'b1;
    bus.addr   = 32'h40;
    bus.datain = 32'h55;
    @(posedge clk);
    #1;
    bus.wmem = 1'b0;
    bus.rmem = 1'b0;
    chk("both_rvalid", bus.rvalid, 1'b0);
    load(32'h40, rv, dout);
    chk("both_data", dout, 32'h55);

    // Aliasing modulo 2^AW words, and byte-offset bits ignored.
    store(32'h400, 32'hA5, fs, wt);
    load(32'h0, rv, dout);
    chk("alias_0", dout, 32'hA5);
    load(32'h3, rv, dout);
    chk("alias_3", dout, 32'hA5);
    wait_empty();

    // Reset mid-drain discards the pending store.
    store(32'h24, 32'h1111_1111, fs, wt);
    wait_empty();
    store(32'h24, 32'h2222_2222, fs, wt);
    idle(1);
    clrn = 1'b0;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    chk("midrst_wb_empty", bus.wb_empty, 1'b1);
    idle(4);
    load(32'h24, rv, dout);
    chk("midrst_old", dout, 32'h1111_1111);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
